wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of long-latency writeback entries (power of 2, >=2).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 alu_valid, alu_addr, alu_data  in  1/5/32  single-cycle writeback request; always accepted, no ready.
REQ-005 lsu_valid, lsu_addr, lsu_data  in  1/5/32  long-latency (load/mul) writeback request.
REQ-006 lsu_ready  out  1  long-latency FIFO can accept this cycle.
REQ-007 pend_valid, pend_addr  in  1/5  issue marks destination register pending.
REQ-008 q_addr1, q_addr2  in  5/5  hazard query addresses.
REQ-009 q_busy1, q_busy2  out  1/1  queried register pending (combinational).
REQ-010 rf_we, rf_waddr, rf_wdata  out  1/5/32  register-file write port, registered.

Function
REQ-011 ALU path SHALL have priority: alu_valid in cycle N -> rf_we=1, rf_waddr/rf_wdata = alu_addr/alu_data in cycle N+1.
REQ-012 lsu_valid & lsu_ready SHALL push {addr,data} into an in-order FIFO.
REQ-013 lsu_ready SHALL equal (FIFO count < FIFO_DEPTH), from registered count only; a push and pop in the same cycle while full SHALL not be accepted.
REQ-014 FIFO head SHALL be popped into the output register only in cycles with alu_valid=0; earliest rf_we for an lsu request accepted in cycle N is N+2.
REQ-015 With no selected source, rf_we SHALL be 0 in the next cycle; rf_waddr/rf_wdata SHALL hold their previous values.
REQ-016 Requests addressed to register 0 SHALL be consumed (ALU dropped, FIFO popped) with rf_we=0.
REQ-017 Scoreboard: 32 busy bits; pend_valid with pend_addr!=0 SHALL set bit pend_addr; bit 0 SHALL never be set.
REQ-018 A busy bit SHALL clear on the edge ending a cycle where rf_we=1 and the output register holds an lsu-sourced write to that address.
REQ-019 Same-edge set and clear of one bit: set SHALL win.
REQ-020 ALU writes SHALL not modify the scoreboard (WAW ordering is the issue logic's job).
REQ-021 q_busyK SHALL be busy[q_addrK]; q_addrK=0 SHALL return 0.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH without loss or duplication.

Reset
REQ-023 While rst_n=0: FIFO empty, pointers/count 0, scoreboard all 0, rf_we=0, rf_waddr=0, rf_wdata=0, source flag 0.
REQ-024 Reset asserted mid-operation SHALL discard all queued and in-flight writes; lsu_ready=1 in the first cycle after release.

Configuration
REQ-025 Macro WB_ARBITER_FWD_EN, when defined, SHALL add outputs fwd_hit1/fwd_hit2 (1) and fwd_data1/fwd_data2 (32): fwd_hitK=rf_we & (rf_waddr==q_addrK) & (q_addrK!=0), fwd_dataK=rf_wdata.
REQ-026 Without WB_ARBITER_FWD_EN these ports SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-027 Package wb_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the FIFO entry type {addr[4:0], data[31:0]}.
REQ-028 FIFO SHALL be a sub-module wb_fifo (push/pop/full/empty/count, parameter DEPTH); arbitration, scoreboard and output register stay in wb_arbiter.

Verification
REQ-029 Reset release, then alu_valid=1, addr=5, data=0xDEADBEEF in cycle 1 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 2, rf_we=0 in cycle 3.
REQ-030 pend addr=7; lsu push addr=7 data=0x12345678 while alu_valid held 1 for 3 cycles -> no lsu write during ALU burst, write appears cycle after alu_valid drops; q_busy1(q_addr1=7) stays 1 through the rf_we cycle and 0 the next.
REQ-031 alu_valid held 1, push 4 lsu entries -> lsu_ready=0 after 4th; 5th lsu_valid not accepted; release ALU -> 4 writes in push order, lsu_ready returns 1 after first pop.
REQ-032 alu addr=0 and lsu addr=0 requests -> rf_we never asserts, FIFO empties, scoreboard unchanged.
REQ-033 Same-cycle pend_valid addr=9 and lsu-sourced commit to 9 -> q_busy for 9 remains 1.
REQ-034 Assert rst_n=0 with 3 FIFO entries and busy bits set -> rf_we=0, all q_busy=0, lsu_ready=1 after release, no stale write emitted; with WB_ARBITER_FWD_EN, commit addr=3 with q_addr2=3 -> fwd_hit2=1, fwd_data2=rf_wdata.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the long-latency writeback entry type for the writeback arbiter.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of pending long-latency writebacks; head is visible combinationally as rdata.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                wdata,
  output wb_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU priority, queued long-latency writes, pending scoreboard.
// Define WB_ARBITER_FWD_EN to add the fwd_hit/fwd_data forwarding outputs.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_addr,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  input  logic                  pend_valid,
  input  logic [REG_ADDR_W-1:0] pend_addr,
  input  logic [REG_ADDR_W-1:0] q_addr1,
  input  logic [REG_ADDR_W-1:0] q_addr2,
  output logic                  q_busy1,
  output logic                  q_busy2,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
`ifdef WB_ARBITER_FWD_EN
  ,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [XLEN-1:0]       fwd_data1,
  output logic [XLEN-1:0]       fwd_data2
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t             fifo_wdata, fifo_head;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  logic                  we_q, we_d;
  logic                  src_q, src_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  clr_en;

  assign lsu_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_push  = lsu_valid && !fifo_full;
  assign fifo_wdata = '{addr: lsu_addr, data: lsu_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Writes to x0 are consumed but never reach the register file.
  always_comb begin
    we_d     = 1'b0;
    src_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    fifo_pop = 1'b0;
    if (alu_valid) begin
      if (alu_addr != '0) begin
        we_d    = 1'b1;
        waddr_d = alu_addr;
        wdata_d = alu_data;
      end
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      if (fifo_head.addr != '0) begin
        we_d    = 1'b1;
        src_d   = 1'b1;
        waddr_d = fifo_head.addr;
        wdata_d = fifo_head.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      src_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      src_q   <= src_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Only queued (long-latency) commits retire a pending bit; a new pend on the same edge wins.
  assign clr_en = we_q && src_q;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_bit
        assign busy_d[gi] = (pend_valid && (pend_addr == REG_ADDR_W'(gi))) ? 1'b1 :
                            (clr_en && (waddr_q == REG_ADDR_W'(gi)))      ? 1'b0 :
                            busy_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign q_busy1  = (q_addr1 != '0) && busy_q[q_addr1];
  assign q_busy2  = (q_addr2 != '0) && busy_q[q_addr2];
  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

`ifdef WB_ARBITER_FWD_EN
  assign fwd_hit1  = we_q && (waddr_q == q_addr1) && (q_addr1 != '0);
  assign fwd_hit2  = we_q && (waddr_q == q_addr2) && (q_addr2 != '0);
  assign fwd_data1 = wdata_q;
  assign fwd_data2 = wdata_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; forwarding checks compile in with WB_ARBITER_FWD_EN.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, pend_valid;
  logic [4:0]  alu_addr, lsu_addr, pend_addr, q_addr1, q_addr2;
  logic [31:0] alu_data, lsu_data;
  logic        lsu_ready, q_busy1, q_busy2, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_ARBITER_FWD_EN
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_addr   (lsu_addr),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .q_addr1    (q_addr1),
    .q_addr2    (q_addr2),
    .q_busy1    (q_busy1),
    .q_busy2    (q_busy2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
`ifdef WB_ARBITER_FWD_EN
    ,
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
  endtask

  // Advance one cycle; returns 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    pend_valid = 1'b0; pend_addr = '0;
    q_addr1 = '0; q_addr2 = '0;
    tick(); tick();
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_ready", lsu_ready, 1);
    q_addr1 = 5'd7;
    #1 check("rst_busy", q_busy1, 0);

    // Single ALU writeback
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    check("alu_we", rf_we, 1);
    check("alu_waddr", rf_waddr, 5);
    check("alu_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    check("alu_we_off", rf_we, 0);
    check("alu_hold_addr", rf_waddr, 5);
    check("alu_hold_data", rf_wdata, 32'hDEADBEEF);

    // LSU write waits behind a 3-cycle ALU burst
    pend_valid = 1'b1; pend_addr = 5'd7;
    lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h12345678;
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
    tick();
    pend_valid = 1'b0; lsu_valid = 1'b0;
    alu_addr = 5'd2; alu_data = 32'h22;
    check("burst1_addr", rf_waddr, 1);
    check("burst_busy", q_busy1, 1);
    tick();
    alu_addr = 5'd3; alu_data = 32'h33;
    check("burst2_addr", rf_waddr, 2);
    tick();
    alu_valid = 1'b0;
    check("burst3_addr", rf_waddr, 3);
    check("burst3_data", rf_wdata, 32'h33);
    tick();
    check("lsu_we", rf_we, 1);
    check("lsu_waddr", rf_waddr, 7);
    check("lsu_wdata", rf_wdata, 32'h12345678);
    check("lsu_busy_commit", q_busy1, 1);
    tick();
    check("lsu_we_off", rf_we, 0);
    check("lsu_busy_clear", q_busy1, 0);

    // Fill FIFO behind ALU, overflow attempt, then drain in order
    alu_valid = 1'b1; alu_addr = 5'd4;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'(i);
      lsu_valid = 1'b1; lsu_addr = 5'(10 + i); lsu_data = 32'hA0 + 32'(i);
      check($sformatf("fill_ready%0d", i), lsu_ready, 1);
      tick();
    end
    check("full_ready", lsu_ready, 0);
    lsu_addr = 5'd14; lsu_data = 32'hBAD;
    tick();
    check("full_ready2", lsu_ready, 0);
    lsu_valid = 1'b0; alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("drain_we%0d", i), rf_we, 1);
      check($sformatf("drain_addr%0d", i), rf_waddr, 64'(10 + i));
      check($sformatf("drain_data%0d", i), rf_wdata, 64'(32'hA0 + i));
      if (i == 0) check("drain_ready", lsu_ready, 1);
    end
    tick();
    check("drain_done_we", rf_we, 0);

    // Writes to x0 are swallowed
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF;
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'hEEEE;
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check("x0_alu_we", rf_we, 0);
    tick();
    check("x0_lsu_we", rf_we, 0);
    check("x0_hold_addr", rf_waddr, 13);
    tick();
    check("x0_idle_we", rf_we, 0);
    check("x0_ready", lsu_ready, 1);

    // Same-edge pend set and lsu commit clear on x9
    q_addr2 = 5'd9;
    pend_valid = 1'b1; pend_addr = 5'd9;
    lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h99;
    tick();
    pend_valid = 1'b0; lsu_valid = 1'b0;
    check("sw_busy_set", q_busy2, 1);
    tick();
    check("sw_commit_we", rf_we, 1);
    check("sw_commit_data", rf_wdata, 32'h99);
    pend_valid = 1'b1; pend_addr = 5'd9;
    tick();
    pend_valid = 1'b0;
    check("sw_set_wins", q_busy2, 1);

    // Mid-operation reset discards queue, scoreboard and output register
    q_addr1 = 5'd15;
    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h66;
    pend_valid = 1'b1; pend_addr = 5'd15;
    lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'h33333333;
    tick();
    pend_valid = 1'b0;
    lsu_addr = 5'd9; lsu_data = 32'h99999999;
    tick();
    lsu_addr = 5'd15; lsu_data = 32'h15151515;
    tick();
    lsu_valid = 1'b0;
    check("pre_rst_we", rf_we, 1);
    check("pre_rst_busy15", q_busy1, 1);
    check("pre_rst_ready", lsu_ready, 1);
    rst_n = 1'b0; alu_valid = 1'b0;
    #1;
    check("mid_rst_we", rf_we, 0);
    check("mid_rst_busy1", q_busy1, 0);
    check("mid_rst_busy2", q_busy2, 0);
    check("mid_rst_ready", lsu_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_we%0d", i), rf_we, 0);
      check($sformatf("post_rst_ready%0d", i), lsu_ready, 1);
    end

    // LSU commit to x3 observed on query port 2
    q_addr1 = 5'd4; q_addr2 = 5'd3;
    pend_valid = 1'b1; pend_addr = 5'd3;
    lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'hC0FFEE00;
    tick();
    pend_valid = 1'b0; lsu_valid = 1'b0;
    check("x3_busy", q_busy2, 1);
    tick();
    check("x3_we", rf_we, 1);
    check("x3_waddr", rf_waddr, 3);
    check("x3_wdata", rf_wdata, 32'hC0FFEE00);
`ifdef WB_ARBITER_FWD_EN
    check("fwd_hit2", fwd_hit2, 1);
    check("fwd_data2", fwd_data2, 32'hC0FFEE00);
    check("fwd_hit1_miss", fwd_hit1, 0);
`endif
    tick();
    check("x3_busy_clear", q_busy2, 0);
    check("x3_we_off", rf_we, 0);
`ifdef WB_ARBITER_FWD_EN
    check("fwd_hit2_off", fwd_hit2, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
